// File: rtl/slc3_pkg.sv
// -----------------------------------------------------------------------------
// slc3_pkg
// Shared types and constants for the SLC-3 multiply/divide unit.
//   state_t   : controller states IDLE / RUN / WB
//   op_t      : operation encoding, OP_MUL = 0, OP_DIV = 1
//   bypass_t  : how the WB result is produced (datapath, divide-by-zero
//               constant, or divider-not-built constant)
//   DEFAULT_WIDTH : default operand/result width
// -----------------------------------------------------------------------------
package slc3_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        BYP_NONE  = 2'd0,
        BYP_DBZ   = 2'd1,
        BYP_NODIV = 2'd2
    } bypass_t;

endpackage

// File: rtl/muldiv_datapath.sv
// -----------------------------------------------------------------------------
// muldiv_datapath
// Iterative unsigned multiply (shift-add) and, when MUL_DIV_UNIT_DIV_EN is
// defined, unsigned restoring divide. One iteration per CLK while step is high.
// Three shared registers:
//   reg_a : product accumulator (mul) / partial remainder (div)
//   reg_b : shifting multiplicand (mul) / dividend becoming quotient (div)
//   reg_c : shifting multiplier (mul) / constant divisor (div)
// Ports:
//   CLK       in   clock
//   load      in   capture operand_a/operand_b and clear the accumulator
//   step      in   perform one iteration of the selected operation
//   op        in   operation of the operation in flight
//   operand_a in   multiplicand / dividend
//   operand_b in   multiplier / divisor
//   result    out  low product bits (mul) or quotient (div)
// Macro: MUL_DIV_UNIT_DIV_EN builds the divider path.
// -----------------------------------------------------------------------------
module muldiv_datapath
    import slc3_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             load,
    input  logic             step,
    input  op_t              op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] reg_c;

`ifdef MUL_DIV_UNIT_DIV_EN
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_ge;

    // Restoring-division trial: shift the next dividend bit into the
    // remainder and see whether the divisor fits. The remainder is always
    // below the divisor, so the difference fits back into WIDTH bits.
    always_comb begin
        rem_shift = {reg_a, reg_b[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, reg_c});
        rem_diff  = rem_shift[WIDTH-1:0] - reg_c;
    end
`endif

    // Operand capture on load, then one shift-add or restoring step per cycle.
    always_ff @(posedge CLK) begin
        if (load) begin
            reg_a <= '0;
            reg_b <= operand_a;
            reg_c <= operand_b;
        end else if (step) begin
            if (op == OP_MUL) begin
                if (reg_c[0]) begin
                    reg_a <= reg_a + reg_b;
                end
                reg_b <= reg_b << 1;
                reg_c <= reg_c >> 1;
            end
`ifdef MUL_DIV_UNIT_DIV_EN
            else begin
                reg_a <= rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
                reg_b <= {reg_b[WIDTH-2:0], rem_ge};
            end
`endif
        end
    end

`ifdef MUL_DIV_UNIT_DIV_EN
    assign result = (op == OP_DIV) ? reg_b : reg_a;
`else
    assign result = reg_a;
`endif

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Multi-cycle unsigned multiply/divide unit writing its result into the
// register file. FSM IDLE -> RUN (WIDTH iterations) -> WB -> IDLE; a divide
// by zero (or a divide without the divider built) skips RUN.
// Outputs Done/LD_REG/DR/Result/Div_By_Zero are registered from the WB state,
// so they appear in the cycle following WB.
// Ports:
//   CLK          in   clock, rising edge
//   Reset        in   synchronous active-low reset
//   Start        in   request, sampled only in IDLE
//   Op           in   0 = multiply, 1 = divide
//   DR_in        in   destination register index
//   Operand_A    in   multiplicand / dividend
//   Operand_B    in   multiplier / divisor
//   Busy         out  high in RUN and WB
//   Done         out  one-cycle completion pulse
//   Result       out  product or quotient, held between operations
//   LD_REG       out  register-file write enable
//   DR           out  register-file write index
//   Div_By_Zero  out  sticky flag, cleared on the next accepted Start
// Macro: MUL_DIV_UNIT_DIV_EN builds the divider and Div_By_Zero logic.
// -----------------------------------------------------------------------------
module mul_div_unit
    import slc3_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Op,
    input  logic [2:0]       DR_in,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             LD_REG,
    output logic [2:0]       DR,
    output logic             Div_By_Zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    op_t              op_q;
    bypass_t          bypass;
    logic [2:0]       dr_q;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dp_result;
    logic             dp_load;
    logic             dp_step;

    assign Busy    = (state != IDLE);
    assign dp_load = (state == IDLE) && Start;
    assign dp_step = (state == RUN);

`ifdef MUL_DIV_UNIT_DIV_EN
    logic dbz_flag;
    assign Div_By_Zero = dbz_flag;
`else
    assign Div_By_Zero = 1'b0;
`endif

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .CLK       (CLK),
        .load      (dp_load),
        .step      (dp_step),
        .op        (op_q),
        .operand_a (Operand_A),
        .operand_b (Operand_B),
        .result    (dp_result)
    );

    // Controller: accepts requests in IDLE, counts iterations in RUN and
    // issues the register-file write from WB. Done/LD_REG default low so
    // they pulse for exactly one cycle and a reset never leaves a write behind.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state  <= IDLE;
            op_q   <= OP_MUL;
            bypass <= BYP_NONE;
            dr_q   <= '0;
            count  <= '0;
            Done   <= 1'b0;
            LD_REG <= 1'b0;
            DR     <= '0;
            Result <= '0;
`ifdef MUL_DIV_UNIT_DIV_EN
            dbz_flag <= 1'b0;
`endif
        end else begin
            Done   <= 1'b0;
            LD_REG <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_q  <= op_t'(Op);
                        dr_q  <= DR_in;
                        count <= '0;
`ifdef MUL_DIV_UNIT_DIV_EN
                        dbz_flag <= 1'b0;
`endif
                        if (op_t'(Op) == OP_MUL) begin
                            bypass <= BYP_NONE;
                            state  <= RUN;
                        end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
                            if (Operand_B == '0) begin
                                bypass <= BYP_DBZ;
                                state  <= WB;
                            end else begin
                                bypass <= BYP_NONE;
                                state  <= RUN;
                            end
`else
                            bypass <= BYP_NODIV;
                            state  <= WB;
`endif
                        end
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= WB;
                    end
                end
                WB: begin
                    Done   <= 1'b1;
                    LD_REG <= (bypass != BYP_NODIV);
                    DR     <= dr_q;
                    case (bypass)
                        BYP_DBZ:   Result <= '1;
                        BYP_NODIV: Result <= '0;
                        default:   Result <= dp_result;
                    endcase
`ifdef MUL_DIV_UNIT_DIV_EN
                    if (bypass == BYP_DBZ) begin
                        dbz_flag <= 1'b1;
                    end
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Directed, table-driven bench for mul_div_unit (WIDTH = 16). Expectations
// follow the MUL_DIV_UNIT_DIV_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam int W        = 16;
    localparam int LAT_FULL = W + 1;
    localparam int LAT_SKIP = 1;
    localparam int BUDGET   = 40;

    logic         CLK       = 1'b0;
    logic         Reset     = 1'b0;
    logic         Start     = 1'b0;
    logic         Op        = 1'b0;
    logic [2:0]   DR_in     = '0;
    logic [W-1:0] Operand_A = '0;
    logic [W-1:0] Operand_B = '0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic         LD_REG;
    logic [2:0]   DR;
    logic         Div_By_Zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   dr;
        logic [W-1:0] res;
        logic         ld;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    mul_div_unit #(
        .WIDTH(W)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Start       (Start),
        .Op          (Op),
        .DR_in       (DR_in),
        .Operand_A   (Operand_A),
        .Operand_B   (Operand_B),
        .Busy        (Busy),
        .Done        (Done),
        .Result      (Result),
        .LD_REG      (LD_REG),
        .DR          (DR),
        .Div_By_Zero (Div_By_Zero)
    );

    // 10 ns clock.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] dr, input logic [W-1:0] res, input logic ld,
                          input logic dbz, input int lat);
        vec_t v;
        v = '{op, a, b, dr, res, ld, dbz, lat};
        vecs.push_back(v);
    endtask

    // Drives a request just after an edge, holds it over one rising edge,
    // then scrambles the inputs so only latched values can produce the result.
    task automatic applyStimulus(input logic op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [2:0] dr);
        Start     = 1'b1;
        Op        = op;
        Operand_A = a;
        Operand_B = b;
        DR_in     = dr;
        @(posedge CLK);
        #1;
        Start     = 1'b0;
        Op        = 1'b0;
        Operand_A = '0;
        Operand_B = '0;
        DR_in     = '0;
    endtask

    // Runs one operation and checks the completion cycle. ignore_at > 0 pulses
    // a conflicting Start sampled at edge t+ignore_at. tail checks the cycle
    // after Done.
    task automatic runOp(input string tag, input vec_t v, input int ignore_at, input bit tail);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        applyStimulus(v.op, v.a, v.b, v.dr);
        checkOutput({tag, " busy"}, 32'(Busy), 32'd1);
        checkOutput({tag, " dbz cleared"}, 32'(Div_By_Zero), 32'd0);
        while (!seen && cyc < BUDGET) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (Done) begin
                seen = 1'b1;
            end else if (ignore_at > 0 && cyc == ignore_at - 1) begin
                Start     = 1'b1;
                Op        = 1'b0;
                Operand_A = '1;
                Operand_B = '1;
                DR_in     = 3'd1;
            end else if (ignore_at > 0 && cyc == ignore_at) begin
                Start     = 1'b0;
                Operand_A = '0;
                Operand_B = '0;
                DR_in     = '0;
            end
        end
        checkOutput({tag, " latency"}, 32'(cyc), 32'(v.lat));
        checkOutput({tag, " result"}, 32'(Result), 32'(v.res));
        checkOutput({tag, " ld_reg"}, 32'(LD_REG), 32'(v.ld));
        if (v.ld) begin
            checkOutput({tag, " dr"}, 32'(DR), 32'(v.dr));
        end
        checkOutput({tag, " dbz"}, 32'(Div_By_Zero), 32'(v.dbz));
        if (tail) begin
            @(posedge CLK);
            #1;
            checkOutput({tag, " done pulse"}, 32'(Done), 32'd0);
            checkOutput({tag, " ld pulse"}, 32'(LD_REG), 32'd0);
            checkOutput({tag, " idle"}, 32'(Busy), 32'd0);
            checkOutput({tag, " dbz sticky"}, 32'(Div_By_Zero), 32'(v.dbz));
        end
    endtask

    initial begin
        vec_t v;
        int ld_pulses;

        // Vector table: op, A, B, DR_in, expected Result, LD_REG, Div_By_Zero, latency.
        addVec(1'b0, 16'h0003, 16'h0005, 3'd2, 16'h000F, 1'b1, 1'b0, LAT_FULL);
        addVec(1'b0, 16'hFFFF, 16'hFFFF, 3'd7, 16'h0001, 1'b1, 1'b0, LAT_FULL);
        addVec(1'b0, 16'h0000, 16'hABCD, 3'd1, 16'h0000, 1'b1, 1'b0, LAT_FULL);
        addVec(1'b0, 16'h00FF, 16'h0101, 3'd3, 16'hFFFF, 1'b1, 1'b0, LAT_FULL);
        addVec(1'b0, 16'h8000, 16'h0002, 3'd4, 16'h0000, 1'b1, 1'b0, LAT_FULL);
`ifdef MUL_DIV_UNIT_DIV_EN
        addVec(1'b1, 16'h0064, 16'h0007, 3'd6, 16'h000E, 1'b1, 1'b0, LAT_FULL);
        addVec(1'b1, 16'hFFFF, 16'h0010, 3'd5, 16'h0FFF, 1'b1, 1'b0, LAT_FULL);
        addVec(1'b1, 16'h1234, 16'h0000, 3'd6, 16'hFFFF, 1'b1, 1'b1, LAT_SKIP);
        addVec(1'b1, 16'h0005, 16'h0009, 3'd2, 16'h0000, 1'b1, 1'b0, LAT_FULL);
        addVec(1'b1, 16'hFFFF, 16'hFFFF, 3'd3, 16'h0001, 1'b1, 1'b0, LAT_FULL);
        addVec(1'b1, 16'hFFFF, 16'h0001, 3'd1, 16'hFFFF, 1'b1, 1'b0, LAT_FULL);
`else
        addVec(1'b1, 16'h1234, 16'h0005, 3'd4, 16'h0000, 1'b0, 1'b0, LAT_SKIP);
        addVec(1'b0, 16'h0007, 16'h0009, 3'd5, 16'h003F, 1'b1, 1'b0, LAT_FULL);
`endif

        // Reset state.
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset busy", 32'(Busy), 32'd0);
        checkOutput("reset done", 32'(Done), 32'd0);
        checkOutput("reset ld_reg", 32'(LD_REG), 32'd0);
        checkOutput("reset dr", 32'(DR), 32'd0);
        checkOutput("reset result", 32'(Result), 32'd0);
        checkOutput("reset dbz", 32'(Div_By_Zero), 32'd0);
        Reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            runOp($sformatf("vec%0d", i), vecs[i], 0, 1'b1);
        end

        // Start pulsed mid-RUN must not disturb the operation in flight.
        v = '{1'b0, 16'h1234, 16'h0100, 3'd5, 16'h3400, 1'b1, 1'b0, LAT_FULL};
        runOp("ignored start", v, 5, 1'b1);

        // Back-to-back: next request issued in the Done cycle.
        v = '{1'b0, 16'h0011, 16'h0011, 3'd6, 16'h0121, 1'b1, 1'b0, LAT_FULL};
        runOp("b2b first", v, 0, 1'b0);
        v = '{1'b0, 16'h0100, 16'h0003, 3'd7, 16'h0300, 1'b1, 1'b0, LAT_FULL};
        runOp("b2b second", v, 0, 1'b1);

        // Reset asserted at edge t+6 of a multiply.
        applyStimulus(1'b0, 16'h0003, 16'h0005, 3'd2);
        repeat (5) @(posedge CLK);
        #1;
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        checkOutput("abort busy", 32'(Busy), 32'd0);
        checkOutput("abort result", 32'(Result), 32'd0);
        checkOutput("abort dr", 32'(DR), 32'd0);
        checkOutput("abort done", 32'(Done), 32'd0);
        ld_pulses = 0;
        repeat (20) begin
            @(posedge CLK);
            #1;
            if (LD_REG) ld_pulses++;
        end
        checkOutput("abort no ld_reg", 32'(ld_pulses), 32'd0);

        // The unit recovers normally after the abort.
        runOp("after abort", vecs[0], 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
